// File: rtl/wbu_pipe.sv
// wbu_pipe: registered, handshaked writeback stage.
// Selects the destination value for one instruction at a time. Loads wait for the memory
// response, then get lane-extracted and sign/zero-extended. Drives the register-file write
// port and a one-cycle commit pulse. Every output comes from a flop.
module wbu_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [XLEN-1:0]    in_pc_imm,
    input  logic [XLEN-1:0]    in_snpc,
    input  logic [XLEN-1:0]    in_alu_result,
    input  logic [2:0]         in_sel,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_rd_wen,
    input  logic [1:0]         in_ld_size,
    input  logic               in_ld_unsigned,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic               rf_wen,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               commit_valid,
    output logic [XLEN-1:0]    commit_pc
);

    localparam int unsigned OffW = $clog2(XLEN / 8);

    localparam logic [2:0] SelImm   = 3'd1;
    localparam logic [2:0] SelPcImm = 3'd2;
    localparam logic [2:0] SelSnpc  = 3'd3;
    localparam logic [2:0] SelMem   = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StWaitMem,
        StWrite
    } state_e;

    state_e state_q, state_d;

    // Load attributes held while waiting for memory
    logic            rd_wen_q, rd_wen_d;
    logic [1:0]      ld_size_q, ld_size_d;
    logic            ld_unsigned_q, ld_unsigned_d;
    logic [OffW-1:0] ld_off_q, ld_off_d;

    // Output registers
    logic               rf_wen_q, rf_wen_d;
    logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
    logic               commit_valid_q, commit_valid_d;
    logic [XLEN-1:0]    commit_pc_q, commit_pc_d;

    logic            accept;
    logic [XLEN-1:0] sel_value;
    logic [1:0]      size_eff;
    logic [OffW-1:0] lane_mask;
    logic [OffW-1:0] byte_off;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] width_mask;
    logic [XLEN-1:0] sign_mask;
    logic [XLEN-1:0] load_value;

    assign in_ready = (state_q != StWaitMem);
    assign accept   = in_valid && in_ready;

    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;

    // Non-load result select; unused encodings fall back to the ALU result
    always_comb begin
        sel_value = in_alu_result;
        case (in_sel)
            SelImm:   sel_value = in_imm;
            SelPcImm: sel_value = in_pc_imm;
            SelSnpc:  sel_value = in_snpc;
            default:  sel_value = in_alu_result;
        endcase
    end

    // Load formatting: clear sub-size address bits to find the natural lane, shift it down,
    // then mask to the access width and extend
    always_comb begin
        size_eff = ld_size_q;
        if (XLEN == 32 && ld_size_q == 2'd3) begin
            size_eff = 2'd2;
        end
        lane_mask  = OffW'((32'd1 << size_eff) - 32'd1);
        byte_off   = ld_off_q & ~lane_mask;
        shifted    = mem_rdata >> {byte_off, 3'b000};
        width_mask = {XLEN{1'b1}} >> (XLEN - (32'd8 << size_eff));
        sign_mask  = width_mask ^ (width_mask >> 1);
        load_value = shifted & width_mask;
        if (!ld_unsigned_q && |(shifted & sign_mask)) begin
            load_value = load_value | ~width_mask;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state_q;
        rd_wen_d       = rd_wen_q;
        ld_size_d      = ld_size_q;
        ld_unsigned_d  = ld_unsigned_q;
        ld_off_d       = ld_off_q;
        rf_wen_d       = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        commit_valid_d = 1'b0;
        commit_pc_d    = commit_pc_q;

        case (state_q)
            StWaitMem: begin
                if (mem_rvalid) begin
                    state_d        = StWrite;
                    rf_wdata_d     = load_value;
                    rf_wen_d       = rd_wen_q && (rf_waddr_q != '0);
                    commit_valid_d = 1'b1;
                end
            end
            default: begin
                // Idle and Write both accept; Write drops to Idle when nothing arrives
                state_d = StIdle;
                if (accept) begin
                    rd_wen_d      = in_rd_wen;
                    ld_size_d     = in_ld_size;
                    ld_unsigned_d = in_ld_unsigned;
                    ld_off_d      = in_alu_result[OffW-1:0];
                    rf_waddr_d    = in_rd;
                    commit_pc_d   = in_pc;
                    if (in_sel == SelMem) begin
                        state_d = StWaitMem;
                    end else begin
                        state_d        = StWrite;
                        rf_wdata_d     = sel_value;
                        rf_wen_d       = in_rd_wen && (in_rd != '0);
                        commit_valid_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            rd_wen_q       <= 1'b0;
            ld_size_q      <= 2'd0;
            ld_unsigned_q  <= 1'b0;
            ld_off_q       <= '0;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
        end else begin
            state_q        <= state_d;
            rd_wen_q       <= rd_wen_d;
            ld_size_q      <= ld_size_d;
            ld_unsigned_q  <= ld_unsigned_d;
            ld_off_q       <= ld_off_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
        end
    end

endmodule

// File: tb/tb_wbu_pipe.sv
// Bench for wbu_pipe: transaction-level model checked every cycle on the XLEN=32 instance,
// directed literal expectations on both an XLEN=32 and an XLEN=64 instance.
module tb_wbu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_imm, in_pc_imm, in_snpc, in_alu_result;
    logic [2:0]  in_sel;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [63:0] w_in_pc, w_in_alu_result;
    logic [2:0]  w_in_sel;
    logic [4:0]  w_in_rd;
    logic [1:0]  w_in_ld_size;
    logic        w_in_ld_unsigned;
    logic        w_mem_rvalid;
    logic [63:0] w_mem_rdata;
    logic        w_rf_wen;
    logic [4:0]  w_rf_waddr;
    logic [63:0] w_rf_wdata;
    logic        w_commit_valid;
    logic [63:0] w_commit_pc;

    int unsigned total  = 0;
    int unsigned passed = 0;
    logic        chk_en = 1'b0;

    always #5 clk = ~clk;

    wbu_pipe #(.XLEN(32), .RADDR_W(5)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pc_imm      (in_pc_imm),
        .in_snpc        (in_snpc),
        .in_alu_result  (in_alu_result),
        .in_sel         (in_sel),
        .in_rd          (in_rd),
        .in_rd_wen      (in_rd_wen),
        .in_ld_size     (in_ld_size),
        .in_ld_unsigned (in_ld_unsigned),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc)
    );

    wbu_pipe #(.XLEN(64), .RADDR_W(5)) u_dut64 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (w_in_valid),
        .in_ready       (w_in_ready),
        .in_pc          (w_in_pc),
        .in_imm         (64'h1111_1111_1111_1111),
        .in_pc_imm      (64'h2222_2222_2222_2222),
        .in_snpc        (64'h3333_3333_3333_3333),
        .in_alu_result  (w_in_alu_result),
        .in_sel         (w_in_sel),
        .in_rd          (w_in_rd),
        .in_rd_wen      (1'b1),
        .in_ld_size     (w_in_ld_size),
        .in_ld_unsigned (w_in_ld_unsigned),
        .mem_rvalid     (w_mem_rvalid),
        .mem_rdata      (w_mem_rdata),
        .rf_wen         (w_rf_wen),
        .rf_waddr       (w_rf_waddr),
        .rf_wdata       (w_rf_wdata),
        .commit_valid   (w_commit_valid),
        .commit_pc      (w_commit_pc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Reference load formatting: pick the byte / half directly, words pass through
    function automatic logic [31:0] fmt32(input logic [1:0] size, input logic uns,
                                          input logic [1:0] off, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*off +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (size)
            2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return d;
        endcase
    endfunction

    // Transaction-level model: one pending load at most; outputs describe the last retire
    logic        m_busy;
    logic [4:0]  p_rd;
    logic        p_wen;
    logic [1:0]  p_size;
    logic        p_uns;
    logic [1:0]  p_off;
    logic [31:0] p_pc;
    logic        e_commit, e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_pc;

    always @(posedge clk) begin
        if (rst) begin
            m_busy   = 1'b0;
            e_commit = 1'b0;
            e_wen    = 1'b0;
            e_waddr  = '0;
            e_wdata  = '0;
            e_pc     = '0;
        end else begin
            e_commit = 1'b0;
            e_wen    = 1'b0;
            if (m_busy) begin
                if (mem_rvalid) begin
                    m_busy   = 1'b0;
                    e_commit = 1'b1;
                    e_wen    = p_wen && (p_rd != 0);
                    e_waddr  = p_rd;
                    e_wdata  = fmt32(p_size, p_uns, p_off, mem_rdata);
                    e_pc     = p_pc;
                end
            end else if (in_valid) begin
                if (in_sel == 3'd4) begin
                    m_busy = 1'b1;
                    p_rd   = in_rd;
                    p_wen  = in_rd_wen;
                    p_size = in_ld_size;
                    p_uns  = in_ld_unsigned;
                    p_off  = in_alu_result[1:0];
                    p_pc   = in_pc;
                end else begin
                    e_commit = 1'b1;
                    e_wen    = in_rd_wen && (in_rd != 0);
                    e_waddr  = in_rd;
                    e_pc     = in_pc;
                    case (in_sel)
                        3'd1:    e_wdata = in_imm;
                        3'd2:    e_wdata = in_pc_imm;
                        3'd3:    e_wdata = in_snpc;
                        default: e_wdata = in_alu_result;
                    endcase
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready", {63'b0, in_ready}, {63'b0, !m_busy});
            chk("m_commit_valid", {63'b0, commit_valid}, {63'b0, e_commit});
            chk("m_rf_wen", {63'b0, rf_wen}, {63'b0, e_wen});
            if (e_commit) begin
                chk("m_rf_waddr", {59'b0, rf_waddr}, {59'b0, e_waddr});
                chk("m_rf_wdata", {32'b0, rf_wdata}, {32'b0, e_wdata});
                chk("m_commit_pc", {32'b0, commit_pc}, {32'b0, e_pc});
            end
        end
    end

    // Present one instruction; every candidate gets a distinct value, val goes to the chosen one
    task automatic drive(input logic [2:0] sel, input logic [4:0] rd, input logic wen,
                         input logic [31:0] pc, input logic [31:0] val,
                         input logic [1:0] size, input logic uns);
        in_valid       = 1'b1;
        in_sel         = sel;
        in_rd          = rd;
        in_rd_wen      = wen;
        in_pc          = pc;
        in_imm         = 32'hA1A1_0001;
        in_pc_imm      = 32'hB2B2_0002;
        in_snpc        = 32'hC3C3_0003;
        in_alu_result  = 32'hD4D4_0004;
        in_ld_size     = size;
        in_ld_unsigned = uns;
        case (sel)
            3'd1:    in_imm = val;
            3'd2:    in_pc_imm = val;
            3'd3:    in_snpc = val;
            default: in_alu_result = val;
        endcase
    endtask

    task automatic issue(input logic [2:0] sel, input logic [4:0] rd, input logic wen,
                         input logic [31:0] pc, input logic [31:0] val,
                         input logic [1:0] size, input logic uns);
        drive(sel, rd, wen, pc, val, size, uns);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sel   = 3'd0;
    endtask

    // Load with mem_rvalid sampled 'delay' edges after the accept edge
    task automatic load(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input int delay,
                        input logic [31:0] rdata);
        issue(3'd4, rd, 1'b1, pc, addr, size, uns);
        idle();
        chk("ld_wait_ready", {63'b0, in_ready}, 64'd0);
        repeat (delay - 1) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
    endtask

    task automatic load64(input string name, input logic [63:0] addr, input logic [1:0] size,
                          input logic uns, input logic [63:0] rdata, input logic [63:0] exp);
        w_in_valid       = 1'b1;
        w_in_sel         = 3'd4;
        w_in_rd          = 5'd9;
        w_in_pc          = 64'h8000_1000;
        w_in_alu_result  = addr;
        w_in_ld_size     = size;
        w_in_ld_unsigned = uns;
        @(negedge clk);
        w_in_valid = 1'b0;
        chk({name, "_ready"}, {63'b0, w_in_ready}, 64'd0);
        w_mem_rvalid = 1'b1;
        w_mem_rdata  = rdata;
        @(negedge clk);
        w_mem_rvalid = 1'b0;
        chk({name, "_commit"}, {63'b0, w_commit_valid}, 64'd1);
        chk({name, "_wen"}, {63'b0, w_rf_wen}, 64'd1);
        chk({name, "_waddr"}, {59'b0, w_rf_waddr}, 64'd9);
        chk({name, "_wdata"}, w_rf_wdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        in_pc = '0; in_imm = '0; in_pc_imm = '0; in_snpc = '0; in_alu_result = '0;
        in_rd = '0; in_rd_wen = 1'b0; in_ld_size = '0; in_ld_unsigned = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        w_in_valid = 1'b0; w_in_sel = '0; w_in_rd = '0; w_in_pc = '0; w_in_alu_result = '0;
        w_in_ld_size = '0; w_in_ld_unsigned = 1'b0; w_mem_rvalid = 1'b0; w_mem_rdata = '0;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_rf_wen", {63'b0, rf_wen}, 64'd0);
        chk("rst_commit", {63'b0, commit_valid}, 64'd0);
        chk("rst_wdata", {32'b0, rf_wdata}, 64'd0);
        chk("rst_waddr", {59'b0, rf_waddr}, 64'd0);
        chk("rst_pc", {32'b0, commit_pc}, 64'd0);
        chk("rst_ready", {63'b0, in_ready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // lui
        issue(3'd1, 5'd5, 1'b1, 32'h8000_0000, 32'h1234_5000, 2'd0, 1'b0);
        idle();
        chk("lui_wen", {63'b0, rf_wen}, 64'd1);
        chk("lui_waddr", {59'b0, rf_waddr}, 64'd5);
        chk("lui_wdata", {32'b0, rf_wdata}, 64'h1234_5000);
        chk("lui_commit", {63'b0, commit_valid}, 64'd1);
        chk("lui_pc", {32'b0, commit_pc}, 64'h8000_0000);
        @(negedge clk);
        chk("lui_pulse_once", {63'b0, commit_valid}, 64'd0);

        // Stray mem_rvalid while idle
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("stray_rvalid", {63'b0, commit_valid}, 64'd0);

        // Byte / half / word loads
        load(5'd6, 32'h8000_0004, 32'h8000_0003, 2'd0, 1'b0, 3, 32'h80FF_7F01);
        chk("lb_wdata", {32'b0, rf_wdata}, 64'hFFFF_FF80);
        chk("lb_wen", {63'b0, rf_wen}, 64'd1);
        load(5'd6, 32'h8000_0008, 32'h8000_0003, 2'd0, 1'b1, 1, 32'h80FF_7F01);
        chk("lbu_wdata", {32'b0, rf_wdata}, 64'h0000_0080);
        load(5'd7, 32'h8000_000C, 32'h8000_0001, 2'd0, 1'b0, 2, 32'h80FF_7F01);
        chk("lb_off1_wdata", {32'b0, rf_wdata}, 64'h0000_007F);
        load(5'd7, 32'h8000_0010, 32'h8000_0002, 2'd1, 1'b0, 1, 32'h8001_1234);
        chk("lh_wdata", {32'b0, rf_wdata}, 64'hFFFF_8001);
        load(5'd7, 32'h8000_0014, 32'h8000_0003, 2'd1, 1'b1, 2, 32'h8001_1234);
        chk("lhu_misalign_wdata", {32'b0, rf_wdata}, 64'h0000_8001);
        load(5'd8, 32'h8000_0018, 32'h8000_0001, 2'd2, 1'b0, 1, 32'hDEAD_BEEF);
        chk("lw_misalign_wdata", {32'b0, rf_wdata}, 64'hDEAD_BEEF);
        load(5'd8, 32'h8000_001C, 32'h8000_0000, 2'd3, 1'b0, 1, 32'h1357_9BDF);
        chk("ld_on_32_wdata", {32'b0, rf_wdata}, 64'h1357_9BDF);
        @(negedge clk);

        // jal to x0, and an instruction with rd_wen clear
        issue(3'd3, 5'd0, 1'b1, 32'h8000_0020, 32'h8000_0008, 2'd0, 1'b0);
        idle();
        chk("jal_x0_commit", {63'b0, commit_valid}, 64'd1);
        chk("jal_x0_wen", {63'b0, rf_wen}, 64'd0);
        issue(3'd2, 5'd4, 1'b0, 32'h8000_0024, 32'h8000_5024, 2'd0, 1'b0);
        idle();
        chk("nowen_wen", {63'b0, rf_wen}, 64'd0);
        chk("auipc_wdata", {32'b0, rf_wdata}, 64'h8000_5024);
        @(negedge clk);

        // Three back-to-back ALU results, then sel=5 treated as ALU
        for (int i = 1; i <= 3; i++) begin
            issue(3'd0, 5'(i), 1'b1, 32'h8000_0100 + 32'(4 * i), 32'(i), 2'd0, 1'b0);
            chk("b2b_wen", {63'b0, rf_wen}, 64'd1);
            chk("b2b_waddr", {59'b0, rf_waddr}, 64'(i));
            chk("b2b_wdata", {32'b0, rf_wdata}, 64'(i));
            chk("b2b_ready", {63'b0, in_ready}, 64'd1);
        end
        issue(3'd5, 5'd9, 1'b1, 32'h8000_0200, 32'h0000_0ABC, 2'd0, 1'b0);
        idle();
        chk("sel5_wdata", {32'b0, rf_wdata}, 64'h0000_0ABC);
        @(negedge clk);

        // Load with the next instruction held valid during the wait; it lands in the WRITE cycle
        issue(3'd4, 5'd10, 1'b1, 32'h8000_0300, 32'h8000_0002, 2'd1, 1'b1);
        drive(3'd0, 5'd11, 1'b1, 32'h8000_0304, 32'h0000_0055, 2'd0, 1'b0);
        @(negedge clk);
        chk("hold_not_taken", {63'b0, commit_valid}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBEEF_0000;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("hold_load_wdata", {32'b0, rf_wdata}, 64'h0000_BEEF);
        chk("hold_load_waddr", {59'b0, rf_waddr}, 64'd10);
        chk("hold_write_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        idle();
        chk("hold_next_waddr", {59'b0, rf_waddr}, 64'd11);
        chk("hold_next_wdata", {32'b0, rf_wdata}, 64'h0000_0055);
        @(negedge clk);

        // Reset during WAIT_MEM, stray response later
        issue(3'd4, 5'd12, 1'b1, 32'h8000_0400, 32'h8000_0000, 2'd2, 1'b0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rstwait_commit", {63'b0, commit_valid}, 64'd0);
        chk("rstwait_wen", {63'b0, rf_wen}, 64'd0);
        chk("rstwait_wdata", {32'b0, rf_wdata}, 64'd0);
        chk("rstwait_waddr", {59'b0, rf_waddr}, 64'd0);
        chk("rstwait_pc", {32'b0, commit_pc}, 64'd0);
        chk("rstwait_ready", {63'b0, in_ready}, 64'd1);

        // Reset coincident with an accept
        drive(3'd1, 5'd13, 1'b1, 32'h8000_0500, 32'h5555_5000, 2'd0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("rstacc_commit", {63'b0, commit_valid}, 64'd0);
        @(negedge clk);
        chk("rstacc_after", {63'b0, commit_valid}, 64'd0);

        // Reset coincident with mem_rvalid
        issue(3'd4, 5'd14, 1'b1, 32'h8000_0600, 32'h8000_0000, 2'd2, 1'b0);
        idle();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h6666_6666;
        rst        = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b0;
        chk("rstmem_commit", {63'b0, commit_valid}, 64'd0);
        @(negedge clk);
        chk("rstmem_after", {63'b0, commit_valid}, 64'd0);
        chk("rstmem_ready", {63'b0, in_ready}, 64'd1);

        // XLEN=64 loads
        load64("ld64", 64'h8000_0000, 2'd3, 1'b0, 64'h8000_0000_0000_0001,
               64'h8000_0000_0000_0001);
        load64("lw64", 64'h8000_0004, 2'd2, 1'b0, 64'h8000_0000_1234_5678,
               64'hFFFF_FFFF_8000_0000);
        load64("lwu64", 64'h8000_0000, 2'd2, 1'b1, 64'h1234_5678_9ABC_DEF0,
               64'h0000_0000_9ABC_DEF0);
        load64("lbu64", 64'h8000_0005, 2'd0, 1'b1, 64'h0000_AB00_0000_0000,
               64'h0000_0000_0000_00AB);
        load64("lh64", 64'h8000_0007, 2'd1, 1'b0, 64'hC001_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_C001);
        @(negedge clk);
        chk("w64_idle_commit", {63'b0, w_commit_valid}, 64'd0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wbu_pipe.md
# wbu_pipe

Registered, handshaked writeback stage for the npc core, the pipelined successor of the combinational writeback select. It accepts one instruction's result candidates from EXU/LSU over a valid/ready handshake and selects the destination value (ALU, immediate, pc+imm, snpc or memory). For loads it waits for the memory response, then extracts, sign- or zero-extends and aligns the data. It drives the register-file write port and a one-cycle commit pulse, and is parametrised in data width.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64
- RADDR_W, 5, register index width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept; equals (state != WAIT_MEM)
- in_pc  in  XLEN  pc of the instruction, reported at commit
- in_imm / in_pc_imm / in_snpc / in_alu_result  in  XLEN  candidate results; in_alu_result is also the load address
- in_sel  in  3  source: 0 ALU, 1 IMM (lui), 2 PC_IMM (auipc), 3 SNPC (jal/jalr), 4 MEM (load); 5–7 treated as ALU
- in_rd  in  RADDR_W  destination register
- in_rd_wen  in  1  instruction writes rd
- in_ld_size  in  2  0 byte, 1 half, 2 word, 3 dword
- in_ld_unsigned  in  1  zero-extend when 1, sign-extend when 0
- mem_rvalid  in  1  load data valid this cycle
- mem_rdata  in  XLEN  raw aligned memory word
- rf_wen / rf_waddr / rf_wdata  out  1 / RADDR_W / XLEN  register-file write port, registered
- commit_valid  out  1  one-cycle retire pulse, registered
- commit_pc  out  XLEN  pc of the retiring instruction

## Operation
- States: IDLE, WAIT_MEM, WRITE; reset state IDLE.
- Accept occurs when in_valid && in_ready. All in_* fields are latched on accept.
- Accept with sel != MEM:
  - Selected value is registered into rf_wdata.
  - rf_waddr = in_rd; commit_pc = in_pc.
  - Next state is WRITE.
- Accept with sel == MEM: next state is WAIT_MEM. Outputs rf_wen and commit_valid are 0 next cycle.
- WAIT_MEM:
  - in_ready = 0.
  - On mem_rvalid: the formatted load value is registered into rf_wdata, and state goes to WRITE.
  - Otherwise the stage holds indefinitely.
- WRITE:
  - rf_wen = latched rd_wen && (rd != 0). commit_valid = 1 for exactly this cycle.
  - in_ready = 1. A new accept in the same cycle goes to WRITE or WAIT_MEM as above; with no accept, state goes to IDLE.
- Load formatting, with off = in_alu_result[log2(XLEN/8)-1:0]:
  - byte: lane off, bits [8*off+7 : 8*off].
  - half: lane off>>1.
  - word: lane off>>2; when XLEN=32, the whole word.
  - dword: whole word, only when XLEN=64.
  - Extension to XLEN is per in_ld_unsigned.
- Misalignment: low address bits below the access size are ignored (natural lane). No exception is raised.
- XLEN=32 with ld_size 3 is treated as word.
- mem_rvalid outside WAIT_MEM is ignored.
- Writes to x0: commit_valid still pulses, rf_wen stays 0.

## Timing
- Reset: state IDLE. rf_wen=0, rf_waddr=0, rf_wdata=0, commit_valid=0, commit_pc=0. in_ready=1 from the first cycle after reset.
- Non-load latency: accepted at edge N, rf_wen/commit_valid are high during cycle N+1.
- Load latency: mem_rvalid sampled at edge M, write/commit are high during cycle M+1.
- Throughput:
  - One non-load per cycle, back-to-back.
  - After a load accept, in_ready is 0 from the next cycle until the edge that samples mem_rvalid. It is 1 in the WRITE cycle.
- rf_wen and commit_valid are high only in WRITE cycles. No output is combinational from in_* or mem_*.
- rst in any state, including WAIT_MEM or coincident with in_valid or mem_rvalid:
  - Next cycle is IDLE with all outputs at reset values.
  - No write or commit occurs for the aborted instruction.
  - A later stray mem_rvalid is ignored.

## Test plan
- lui, XLEN=32: sel=1, imm=0x12345000, rd=5, pc=0x80000000 -> next cycle rf_wen=1, waddr=5, wdata=0x12345000, commit_valid=1, commit_pc=0x80000000.
- lb then lbu: alu_result=0x80000003, mem_rvalid 3 cycles after accept with rdata=0x80FF7F01 -> in_ready=0 for those cycles. lb writes 0xFFFFFF80; lbu writes 0x00000080, one cycle after mem_rvalid.
- lh/lhu: alu_result=0x80000002, rdata=0x80011234 -> lh writes 0xFFFF8001, lhu writes 0x00008001. With XLEN=64, ld dword of 0x8000000000000001 writes it unchanged.
- jal with rd=0, snpc=0x80000008 -> commit_valid=1, rf_wen=0.
- Three consecutive ALU accepts (results 1, 2, 3 to rd 1, 2, 3) -> rf_wen high on three consecutive cycles with matching waddr/wdata, and in_ready stays 1.
- rst asserted during WAIT_MEM, mem_rvalid 2 cycles later -> no rf_wen and no commit_valid; outputs stay 0; in_ready=1.
